cordic_phase_prep: RTL and testbench



---
 rtl/cordic_pkg.sv | 18 +
 rtl/cordic_delay_line.sv | 27 ++
 rtl/cordic_phase_prep.sv | 156 +++++++++++++++
 tb/tb_cordic_phase_prep.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC sine/cosine front end.
// Angles use signed Q2.6 radians at the core input; the core emits Q1.7 results.
package cordic_pkg;

  localparam int ANGLE_W    = 8;
  localparam int ANGLE_FRAC = 6;
  localparam int OUT_FRAC   = 7;

  // 804 / 2^17 approximates 2*pi*64 / 2^16: phase units to Q2.6 radians.
  localparam int SCALE_K  = 804;
  localparam int SCALE_SH = 17;

  // A quarter turn of the 16-bit phase accumulator.
  localparam int QUARTER  = 16384;

  typedef logic signed [ANGLE_W-1:0] angle_t;

endpackage

// File: rtl/cordic_delay_line.sv
// Fixed-depth shift register for side-band flags that must stay aligned with
// the CORDIC core outputs. Advances every clock; async active-low clear.
module cordic_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift the flag word one stage per clock, oldest entry at the far end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/cordic_phase_prep.sv
// Phase accumulator and angle preparation ahead of the pipelined CORDIC core.
// The phase is folded into [-pi/2, pi/2], scaled to Q2.6 radians and a
// cosine-negate flag is delayed to line up with the core outputs.
// Optional build macro: CORDIC_PHASE_DITHER_EN adds LFSR phase dither.
module cordic_phase_prep
  import cordic_pkg::*;
#(
  parameter int PHASE_W    = 16,
  parameter int CORDIC_LAT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_load_phase,
  input  logic [PHASE_W-1:0] i_step,
  input  logic               i_en,
  output logic [ANGLE_W-1:0] o_angle_out,
  output logic               o_valid_out,
  output logic               o_cos_neg_out,
  output logic               o_valid_aligned
);

  localparam int PROD_W = PHASE_W + 13;
  localparam logic signed [PHASE_W+1:0] C_HALF = (PHASE_W+2)'(2 * QUARTER);
  localparam logic signed [PHASE_W+1:0] C_FULL = (PHASE_W+2)'(4 * QUARTER);

  logic [PHASE_W-1:0]        r_phase;
  logic [PHASE_W-1:0]        w_sample;
  logic                      w_take;
  logic signed [PHASE_W+1:0] w_ext;
  logic signed [PHASE_W+1:0] w_fold;
  logic                      w_neg;
  logic signed [PHASE_W:0]   r_p;
  logic                      r_neg1;
  logic                      r_v1;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [PROD_W-1:0]  r_prod;
  logic                      r_neg2;
  logic                      r_v2;
  angle_t                    r_angle;
  logic                      r_neg3;
  logic                      r_valid;
  logic [1:0]                w_dlq;

  // Load wins over enable, so a sample is only taken on a pure enable cycle.
  assign w_take = i_en & ~i_load;

  // NCO accumulator: load, or advance by step after sampling, wrapping silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (i_load) begin
      r_phase <= i_load_phase;
    end else if (i_en) begin
      r_phase <= r_phase + i_step;
    end
  end

`ifdef CORDIC_PHASE_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Fibonacci LFSR stepping once per taken sample to spread quantisation spurs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (w_take) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign w_sample = r_phase + PHASE_W'(r_lfsr[5:0]);
`else
  assign w_sample = r_phase;
`endif

  // Fold quadrants 1/2 onto [-pi/2, pi/2] via pi - x and shift quadrant 3 down a turn.
  always_comb begin
    w_ext  = signed'({2'b00, w_sample});
    w_fold = w_ext;
    w_neg  = 1'b0;
    case (w_sample[PHASE_W-1 -: 2])
      2'b01, 2'b10: begin
        w_fold = C_HALF - w_ext;
        w_neg  = 1'b1;
      end
      2'b11:   w_fold = w_ext - C_FULL;
      default: ;
    endcase
  end

  // Stage 1 captures the folded phase and its cosine sign for a taken sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p    <= '0;
      r_neg1 <= 1'b0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= w_take;
      if (w_take) begin
        r_p    <= (PHASE_W+1)'(w_fold);
        r_neg1 <= w_neg;
      end
    end
  end

  assign w_prod = PROD_W'(r_p) * PROD_W'(SCALE_K) + (PROD_W'(1) <<< (SCALE_SH - 1));

  // Multiply stage: scaled phase with the half-LSB rounding offset already added.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod <= '0;
      r_neg2 <= 1'b0;
      r_v2   <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod <= w_prod;
        r_neg2 <= r_neg1;
      end
    end
  end

  // Output stage: arithmetic shift gives round-half-up; range always fits 8 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_angle <= '0;
      r_neg3  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v2;
      if (r_v2) begin
        r_angle <= angle_t'(r_prod >>> SCALE_SH);
        r_neg3  <= r_neg2;
      end
    end
  end

  cordic_delay_line #(
    .WIDTH(2),
    .DEPTH(CORDIC_LAT)
  ) u_flag_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     ({r_valid, r_neg3 & r_valid}),
    .o_q     (w_dlq)
  );

  assign o_angle_out     = r_angle;
  assign o_valid_out     = r_valid;
  assign o_valid_aligned = w_dlq[1];
  assign o_cos_neg_out   = w_dlq[1] & w_dlq[0];

endmodule

// File: tb/tb_cordic_phase_prep.sv
// Self-checking bench for cordic_phase_prep (default build, no dither).
// A phase-level reference model predicts every output cycle; directed tables
// and sequences add fixed expected values for the documented corner cases.
module tb_cordic_phase_prep;

  localparam int LAT  = 8;
  localparam int NCYC = 4096;

  logic        clk;
  logic        rstN;
  logic        load;
  logic        en;
  logic [15:0] loadPhase;
  logic [15:0] step;
  logic [7:0]  angle;
  logic        validOut;
  logic        cosNeg;
  logic        validAligned;

  int cmpCount  = 0;
  int failCount = 0;
  int cyc       = 0;
  int mPhase    = 0;

  logic eV [NCYC];
  int   eA [NCYC];
  logic eN [NCYC];

  typedef struct {
    logic [15:0] lp;
    int          a;
    logic        n;
  } vec_t;

  vec_t tbl [9];

  cordic_phase_prep #(
    .PHASE_W    (16),
    .CORDIC_LAT (LAT)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_load          (load),
    .i_load_phase    (loadPhase),
    .i_step          (step),
    .i_en            (en),
    .o_angle_out     (angle),
    .o_valid_out     (validOut),
    .o_cos_neg_out   (cosNeg),
    .o_valid_aligned (validAligned)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Angle for a phase: nearest quarter-turn fold, then floor((p*804+65536)/2^17).
  function automatic int refAngle(input int ph, output logic neg);
    int     p;
    longint num;
    int     quad;
    quad = ph / 16384;
    case (quad)
      0:       begin p = ph;          neg = 1'b0; end
      1, 2:    begin p = 32768 - ph;  neg = 1'b1; end
      default: begin p = ph - 65536;  neg = 1'b0; end
    endcase
    num = longint'(p) * 804 + 65536;
    if (num >= 0) return int'(num / 131072);
    return -int'((-num + 131071) / 131072);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    cmpCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of all outputs against the model's predictions.
  task automatic checkOutput();
    int   idx;
    logic expVa;
    logic expCn;
    idx   = cyc - LAT;
    expVa = (idx >= 0) ? eV[idx] : 1'b0;
    expCn = (idx >= 0) ? (eV[idx] & eN[idx]) : 1'b0;
    check("mon valid_out", int'(validOut), int'(eV[cyc]));
    if (eV[cyc]) check("mon angle_out", int'($signed(angle)), eA[cyc]);
    check("mon valid_aligned", int'(validAligned), int'(expVa));
    check("mon cos_neg_out", int'(cosNeg), int'(expCn));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input logic ld, input logic [15:0] lp,
                               input logic [15:0] st, input logic e);
    logic n;
    load      = ld;
    loadPhase = lp;
    step      = st;
    en        = e;
    @(posedge clk);
    cyc++;
    if (cyc + LAT + 4 >= NCYC) begin
      $display("[TB] FAIL cycle budget exhausted at cycle %0d", cyc);
      $fatal(1, "[TB] cycle budget");
    end
    if (rstN) begin
      if (ld) begin
        mPhase = int'(lp);
      end else if (e) begin
        eA[cyc+2] = refAngle(mPhase, n);
        eV[cyc+2] = 1'b1;
        eN[cyc+2] = n;
        mPhase    = (mPhase + int'(st)) % 65536;
      end
    end
    #1;
    checkOutput();
  endtask

  // Assert reset between edges, verify immediate clear, hold, release.
  task automatic pulseReset(input int holdCycles);
    int lo;
    #2;
    rstN = 1'b0;
    #1;
    check("rst angle_out", int'(angle), 0);
    check("rst valid_out", int'(validOut), 0);
    check("rst cos_neg_out", int'(cosNeg), 0);
    check("rst valid_aligned", int'(validAligned), 0);
    mPhase = 0;
    lo = (cyc - LAT - 4 < 0) ? 0 : cyc - LAT - 4;
    for (int j = lo; j <= cyc + LAT + 4; j++) begin
      eV[j] = 1'b0;
      eN[j] = 1'b0;
    end
    for (int h = 0; h < holdCycles; h++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    rstN = 1'b1;
  endtask

  initial begin
    int   seqA [5];
    logic seqN [5];
    for (int j = 0; j < NCYC; j++) begin
      eV[j] = 1'b0;
      eA[j] = 0;
      eN[j] = 1'b0;
    end
    tbl[0] = '{16'h2000,   50, 1'b0};
    tbl[1] = '{16'hE000,  -50, 1'b0};
    tbl[2] = '{16'h6000,   50, 1'b1};
    tbl[3] = '{16'h1000,   25, 1'b0};
    tbl[4] = '{16'h4000,  101, 1'b1};
    tbl[5] = '{16'hC000, -100, 1'b0};
    tbl[6] = '{16'h8000,    0, 1'b1};
    tbl[7] = '{16'hA000,  -50, 1'b1};
    tbl[8] = '{16'h0000,    0, 1'b0};
    seqA = '{0, 101, 0, -100, 0};
    seqN = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    load = 1'b0; en = 1'b0; loadPhase = '0; step = '0;
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #1;
    check("init angle_out", int'(angle), 0);
    check("init valid_out", int'(validOut), 0);
    check("init cos_neg_out", int'(cosNeg), 0);
    check("init valid_aligned", int'(validAligned), 0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    rstN = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);

    // Single samples from a table of phases with fixed expected angles.
    $display("[TB] single-sample table");
    foreach (tbl[i]) begin
      applyStimulus(1'b1, tbl[i].lp, 16'h0, 1'b0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      check("tbl early valid_out", int'(validOut), 0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      check("tbl valid_out", int'(validOut), 1);
      check("tbl angle_out", int'($signed(angle)), tbl[i].a);
      for (int k = 0; k < LAT - 1; k++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      check("tbl early valid_aligned", int'(validAligned), 0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      check("tbl valid_aligned", int'(validAligned), 1);
      check("tbl cos_neg_out", int'(cosNeg), int'(tbl[i].n));
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    end

    // Quarter-turn steps: continuous valid, wrap back to phase 0.
    $display("[TB] quarter-turn stream");
    applyStimulus(1'b1, 16'h0000, 16'h0, 1'b0);
    for (int i = 0; i <= 6 + LAT; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h4000, (i < 5));
      if (i >= 2 && i <= 6) begin
        check("seq valid_out", int'(validOut), 1);
        check("seq angle_out", int'($signed(angle)), seqA[i-2]);
      end
      if (i >= 2 + LAT && i <= 6 + LAT) begin
        check("seq valid_aligned", int'(validAligned), 1);
        check("seq cos_neg_out", int'(cosNeg), int'(seqN[i-2-LAT]));
      end
    end

    // Load and enable together: load wins, no sample taken.
    $display("[TB] load beats enable");
    applyStimulus(1'b1, 16'h1000, 16'h0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      check("ldEn no valid_out", int'(validOut), 0);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    check("ldEn valid_out", int'(validOut), 1);
    check("ldEn angle_out", int'($signed(angle)), 25);

    // Reset in the middle of a running stream discards in-flight samples.
    $display("[TB] mid-stream reset");
    applyStimulus(1'b1, 16'h0123, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 16'h0777, 1'b1);
    pulseReset(2);
    for (int i = 0; i < LAT + 3; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      check("post-rst valid_out", int'(validOut), 0);
      check("post-rst valid_aligned", int'(validAligned), 0);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    check("post-rst angle_out", int'($signed(angle)), 0);

    // Random traffic against the model, with one reset in the middle.
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulseReset(1);
      applyStimulus(($urandom_range(0, 9) == 0), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < LAT + 4; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
